// File: rtl/vga_pkg.sv
// Shared VGA-path definitions: raster limits, colour type,
// scale encodings and the overlay configuration bundle.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int RGB_W    = 3;
  localparam int LATENCY  = 2;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [1:0]       scale_t;

  localparam scale_t SCALE_1X = 2'd0;
  localparam scale_t SCALE_2X = 2'd1;
  localparam scale_t SCALE_4X = 2'd2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    scale_t     scale;
    rgb_t       color;
  } ovl_cfg_t;

  // Encoding 3 is reserved and renders as 4x.
  function automatic scale_t scale_shift(scale_t s);
    return (s > SCALE_4X) ? SCALE_4X : s;
  endfunction

endpackage

// File: rtl/text_overlay_if.sv
// Pixel, configuration, ROM and output signals of the
// text overlay; slave is the overlay, master its parent.
interface text_overlay_if
  import vga_pkg::*;
#(
  parameter int WIDTH  = 216,
  parameter int ADDR_W = 6
);
  logic [9:0]        HCount;
  logic [9:0]        VCount;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  scale_t            scale;
  rgb_t              color;
  logic              cfg_load;
  logic              blink_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [WIDTH-1:0]  rom_data;
  logic              titleon;
  rgb_t              rgb;

  modport slave (
    input  HCount, VCount, pos_x, pos_y,
    input  scale, color, cfg_load, blink_en,
    input  rom_data,
    output rom_addr, titleon, rgb
  );

  modport master (
    output HCount, VCount, pos_x, pos_y,
    output scale, color, cfg_load, blink_en,
    output rom_data,
    input  rom_addr, titleon, rgb
  );
endinterface

// File: rtl/text_overlay_blink_ctrl.sv
// Frame counter and visible flag for text blinking;
// the counter only advances on frame boundaries.
module text_blink_ctrl #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_boundary,
  input  logic blink_en,
  output logic visible
);
  localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       vis_q, vis_d;

  always_comb begin
    cnt_d = cnt_q;
    vis_d = vis_q;
    if (!blink_en) begin
      cnt_d = '0;
      vis_d = 1'b1;
    end else if (frame_boundary) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        vis_d = ~vis_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      vis_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      vis_q <= vis_d;
    end
  end

  assign visible = vis_q;
endmodule

// File: rtl/text_overlay.sv
// Two-stage bitmap text overlay: stage 1 addresses the ROM,
// stage 2 picks the pixel bit and colour.
module text_overlay
  import vga_pkg::*;
#(
  parameter int         WIDTH        = 216,
  parameter int         HEIGHT       = 36,
  parameter int         ADDR_W       = 6,
  parameter logic [9:0] X0           = 10'd225,
  parameter logic [9:0] Y0           = 10'd5,
  parameter rgb_t       COLOR0       = 3'b001,
  parameter int         BLINK_FRAMES = 30
) (
  input logic           clk,
  input logic           reset,
  text_overlay_if.slave ov
);
  localparam int COL_W = $clog2(WIDTH);
  localparam ovl_cfg_t CFG0 = '{
    x: X0, y: Y0, scale: SCALE_1X, color: COLOR0
  };

  ovl_cfg_t act_q, act_d, shd_q, shd_d;
  ovl_cfg_t cfg_in, eff;
  logic     boundary, visible, hit;
  scale_t   sh;
  logic [10:0] right, bottom;
  logic [9:0]  dx, dy;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              hit_q, hit_d;
  rgb_t              clr_q, clr_d;
  logic              titleon_q, titleon_d;
  rgb_t              rgb_q, rgb_d;

  assign boundary = (ov.HCount == 10'd0)
                  && (ov.VCount == 10'd0);
  assign cfg_in = '{
    x: ov.pos_x, y: ov.pos_y,
    scale: ov.scale, color: ov.color
  };

  // The boundary pixel already sees the new frame's config.
  always_comb begin
    shd_d = ov.cfg_load ? cfg_in : shd_q;
    eff   = act_q;
    if (boundary) begin
      eff = ov.cfg_load ? cfg_in : shd_q;
    end
    act_d = eff;
  end

  always_comb begin
    sh     = scale_shift(eff.scale);
    right  = {1'b0, eff.x} + (11'(WIDTH) << sh) - 11'd1;
    bottom = {1'b0, eff.y} + (11'(HEIGHT) << sh) - 11'd1;
    hit    = (ov.HCount >= eff.x)
          && ({1'b0, ov.HCount} <= right)
          && (ov.VCount >= eff.y)
          && ({1'b0, ov.VCount} <= bottom);
    dx     = ov.HCount - eff.x;
    dy     = ov.VCount - eff.y;
    hit_d      = hit;
    clr_d      = eff.color;
    col_d      = hit ? COL_W'(dx >> sh) : '0;
    rom_addr_d = hit ? ADDR_W'(dy >> sh) : '0;
  end

  always_comb begin
    titleon_d = hit_q & ov.rom_data[col_q] & visible;
    rgb_d     = titleon_d ? clr_q : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q      <= CFG0;
      shd_q      <= CFG0;
      rom_addr_q <= '0;
      col_q      <= '0;
      hit_q      <= 1'b0;
      clr_q      <= '0;
      titleon_q  <= 1'b0;
      rgb_q      <= '0;
    end else begin
      act_q      <= act_d;
      shd_q      <= shd_d;
      rom_addr_q <= rom_addr_d;
      col_q      <= col_d;
      hit_q      <= hit_d;
      clr_q      <= clr_d;
      titleon_q  <= titleon_d;
      rgb_q      <= rgb_d;
    end
  end

  text_blink_ctrl #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk           (clk),
    .reset         (reset),
    .frame_boundary(boundary),
    .blink_en      (ov.blink_en),
    .visible       (visible)
  );

  assign ov.rom_addr = rom_addr_q;
  assign ov.titleon  = titleon_q;
  assign ov.rgb      = rgb_q;
endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay with a small bitmap ROM
// model and hand-computed pixel expectations.
module tb_text_overlay;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  text_overlay_if #(.WIDTH(216), .ADDR_W(6)) ov();

  logic [215:0] rom [0:63];
  assign ov.rom_data = rom[ov.rom_addr];

  text_overlay #(.BLINK_FRAMES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .ov   (ov)
  );

  logic [9:0] bb_h [0:2] = '{10'd225, 10'd226, 10'd226};
  logic [9:0] bb_v [0:2] = '{10'd5, 10'd5, 10'd6};
  logic       bb_on [0:2] = '{1'b1, 1'b0, 1'b1};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [9:0] x, input logic [9:0] y,
                     input logic [1:0] s, input logic [2:0] c);
    ov.pos_x    = x;
    ov.pos_y    = y;
    ov.scale    = s;
    ov.color    = c;
    ov.cfg_load = 1'b1;
  endtask

  // Pixel then an off-screen filler; result lands 2 edges later.
  task automatic px(input logic [9:0] h, input logic [9:0] v,
                    input logic on, input logic [2:0] c,
                    input string tag);
    ov.HCount = h;
    ov.VCount = v;
    @(posedge clk); #1;
    ov.cfg_load = 1'b0;
    ov.HCount   = 10'd1023;
    ov.VCount   = 10'd1023;
    @(posedge clk); #1;
    check({tag, "_on"}, 32'(ov.titleon), 32'(on));
    check({tag, "_rgb"}, 32'(ov.rgb), 32'(on ? c : 3'b000));
  endtask

  initial begin
    for (int r = 0; r < 64; r++) rom[r] = '0;
    rom[0][0]    = 1'b1;
    rom[0][9]    = 1'b1;
    rom[1][1]    = 1'b1;
    rom[35][215] = 1'b1;

    ov.HCount   = 10'd1023;
    ov.VCount   = 10'd1023;
    ov.pos_x    = '0;
    ov.pos_y    = '0;
    ov.scale    = '0;
    ov.color    = '0;
    ov.cfg_load = 1'b0;
    ov.blink_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_on", 32'(ov.titleon), 32'd0);
    check("rst_rgb", 32'(ov.rgb), 32'd0);
    check("rst_addr", 32'(ov.rom_addr), 32'd0);
    reset = 1'b0;

    px(10'd225, 10'd5, 1'b1, 3'b001, "def_origin");
    px(10'd224, 10'd5, 1'b0, 3'b001, "def_left");
    px(10'd226, 10'd5, 1'b0, 3'b001, "def_clear");
    px(10'd226, 10'd6, 1'b1, 3'b001, "def_row1");
    px(10'd440, 10'd40, 1'b1, 3'b001, "edge_br");
    px(10'd441, 10'd40, 1'b0, 3'b001, "edge_r");
    px(10'd440, 10'd41, 1'b0, 3'b001, "edge_b");

    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        ov.HCount = bb_h[k];
        ov.VCount = bb_v[k];
      end else begin
        ov.HCount = 10'd1023;
        ov.VCount = 10'd1023;
      end
      @(posedge clk); #1;
      if (k >= 1)
        check("b2b_on", 32'(ov.titleon), 32'(bb_on[k-1]));
    end

    cfg(10'd100, 10'd200, 2'd1, 3'b100);
    px(10'd300, 10'd100, 1'b0, 3'b001, "mid_load");
    px(10'd225, 10'd5, 1'b1, 3'b001, "mid_old");
    px(10'd101, 10'd201, 1'b0, 3'b100, "mid_new_early");
    px(10'd0, 10'd0, 1'b0, 3'b100, "mid_bound");
    px(10'd101, 10'd201, 1'b1, 3'b100, "s2_r0c0");
    px(10'd102, 10'd202, 1'b1, 3'b100, "s2_r1c1");
    px(10'd531, 10'd271, 1'b1, 3'b100, "s2_last");
    px(10'd532, 10'd271, 1'b0, 3'b100, "s2_r");
    px(10'd531, 10'd272, 1'b0, 3'b100, "s2_b");
    px(10'd225, 10'd5, 1'b0, 3'b100, "s2_old_gone");

    cfg(10'd0, 10'd0, 2'd0, 3'b010);
    px(10'd0, 10'd0, 1'b1, 3'b010, "bnd_load");
    px(10'd1, 10'd1, 1'b1, 3'b010, "bnd_r1");
    px(10'd2, 10'd1, 1'b0, 3'b010, "bnd_clear");

    ov.blink_en = 1'b1;
    px(10'd1, 10'd1, 1'b1, 3'b010, "blk_f0");
    px(10'd0, 10'd0, 1'b1, 3'b010, "blk_b1");
    px(10'd1, 10'd1, 1'b1, 3'b010, "blk_f1");
    px(10'd0, 10'd0, 1'b0, 3'b010, "blk_b2");
    px(10'd1, 10'd1, 1'b0, 3'b010, "blk_f2");
    px(10'd0, 10'd0, 1'b0, 3'b010, "blk_b3");
    px(10'd1, 10'd1, 1'b0, 3'b010, "blk_f3");
    px(10'd0, 10'd0, 1'b1, 3'b010, "blk_b4");
    px(10'd1, 10'd1, 1'b1, 3'b010, "blk_f4");
    px(10'd0, 10'd0, 1'b1, 3'b010, "blk_b5");
    px(10'd0, 10'd0, 1'b0, 3'b010, "blk_b6");
    ov.blink_en = 1'b0;
    px(10'd1, 10'd1, 1'b1, 3'b010, "blk_off");

    cfg(10'd600, 10'd5, 2'd2, 3'b111);
    px(10'd300, 10'd300, 1'b0, 3'b111, "s4_load");
    px(10'd0, 10'd0, 1'b0, 3'b111, "s4_bound");
    px(10'd600, 10'd5, 1'b1, 3'b111, "s4_first");
    px(10'd639, 10'd5, 1'b1, 3'b111, "s4_last");
    px(10'd599, 10'd5, 1'b0, 3'b111, "s4_left");
    px(10'd0, 10'd5, 1'b0, 3'b111, "s4_wrap0");
    px(10'd10, 10'd5, 1'b0, 3'b111, "s4_wrap10");
    px(10'd604, 10'd6, 1'b0, 3'b111, "s4_c1r0");
    px(10'd600, 10'd9, 1'b0, 3'b111, "s4_c0r1");
    px(10'd604, 10'd9, 1'b1, 3'b111, "s4_c1r1");

    ov.HCount = 10'd600;
    ov.VCount = 10'd5;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_on", 32'(ov.titleon), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_on", 32'(ov.titleon), 32'd0);
    check("async_rst_rgb", 32'(ov.rgb), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ov.HCount = 10'd225;
    ov.VCount = 10'd5;
    @(posedge clk); #1;
    check("post_rst_c1", 32'(ov.titleon), 32'd0);
    @(posedge clk); #1;
    check("post_rst_on", 32'(ov.titleon), 32'd1);
    check("post_rst_rgb", 32'(ov.rgb), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
